contador_binario_universal: RTL and testbench

Parameterised N-bit universal binary counter: synchronous clear, parallel load, enable, and up/down count direction. Combinational terminal-count flags max_tick and min_tick are provided. General-purpose building block for timers, address generators and prescalers; single clock domain.

---
 rtl/contador_binario_universal_pkg.sv | 29 ++
 rtl/contador_binario_universal_next.sv | 31 +++
 rtl/contador_binario_universal.sv | 47 ++++
 tb/tb_contador_binario_universal.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/contador_binario_universal_pkg.sv
// Shared types for the universal counter: next-value source selection and
// the fixed clear > load > count priority encoder.
package contador_binario_universal_pkg;

    typedef enum logic [2:0] {
        SelHold,
        SelClear,
        SelLoad,
        SelUp,
        SelDown
    } sel_e;

    // Priority: syn_clr beats load, load beats counting; up only matters when en = 1.
    function automatic sel_e select_op(input logic syn_clr, input logic load,
                                       input logic en, input logic up);
        sel_e sel;
        if (syn_clr) begin
            sel = SelClear;
        end else if (load) begin
            sel = SelLoad;
        end else if (en) begin
            sel = up ? SelUp : SelDown;
        end else begin
            sel = SelHold;
        end
        return sel;
    endfunction

endpackage

// File: rtl/contador_binario_universal_next.sv
// Combinational next-value mux for the universal counter with +/-1 modulo 2^N.
module contador_binario_universal_next
    import contador_binario_universal_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] r,
    input  logic [N-1:0] d,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] r_next
);

    sel_e sel;

    always_comb begin
        sel    = select_op(syn_clr, load, en, up);
        r_next = r;
        unique case (sel)
            SelClear: r_next = '0;
            SelLoad:  r_next = d;
            SelUp:    r_next = r + N'(1);
            SelDown:  r_next = r - N'(1);
            SelHold:  r_next = r;
            default:  r_next = r;
        endcase
    end

endmodule

// File: rtl/contador_binario_universal.sv
// N-bit universal binary counter: synchronous clear, parallel load, enable,
// up/down direction, and combinational terminal-count flags.
module contador_binario_universal #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;
    logic [N-1:0] r_d;

    contador_binario_universal_next #(
        .N(N)
    ) u_next (
        .r      (r_q),
        .d      (d),
        .syn_clr(syn_clr),
        .load   (load),
        .en     (en),
        .up     (up),
        .r_next (r_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        q        = r_q;
        max_tick = &r_q;
        min_tick = ~|r_q;
    end

endmodule

// File: tb/tb_contador_binario_universal.sv
// Scoreboard bench for the universal counter (N=3): the driver pushes expected
// post-edge state from an arithmetic model, a monitor pops and compares.
module tb_contador_binario_universal;

    localparam int unsigned N = 3;
    localparam int unsigned M = 1 << N;

    logic         clk = 1'b0;
    logic         reset;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         max_tick;
    logic         min_tick;
    logic [N-1:0] q;

    typedef struct packed {
        logic [N-1:0] q;
        logic         mx;
        logic         mn;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned model;
    int          tests = 0;
    int          fails = 0;

    contador_binario_universal #(
        .N(N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .max_tick(max_tick),
        .min_tick(min_tick),
        .q       (q)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_of(input int unsigned v);
        exp_t e;
        e.q  = v[N-1:0];
        e.mx = (v == M - 1);
        e.mn = (v == 0);
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        tests++;
        if (q !== e.q || max_tick !== e.mx || min_tick !== e.mn) begin
            fails++;
            $display("FAIL %s at %0t: got q=%0d max=%b min=%b, expected q=%0d max=%b min=%b",
                     name, $time, q, max_tick, min_tick, e.q, e.mx, e.mn);
        end
    endtask

    // One clock edge of stimulus; the model advances with plain modular arithmetic.
    task automatic step(input logic c, input logic l, input logic e, input logic u,
                        input int unsigned dv);
        @(negedge clk);
        syn_clr = c;
        load    = l;
        en      = e;
        up      = u;
        d       = dv[N-1:0];
        if (c) model = 0;
        else if (l) model = dv % M;
        else if (e) model = u ? (model + 1) % M : (model + M - 1) % M;
        exp_q.push_back(expect_of(model));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("edge", e);
            end
        end
    end

    initial begin : driver
        reset   = 1'b0;
        syn_clr = 1'b0;
        load    = 1'b0;
        en      = 1'b1;
        up      = 1'b1;
        d       = '0;
        model   = 0;

        // Reset held: edges must be ignored even with en = 1.
        repeat (3) @(posedge clk);
        #1 check("reset_hold", expect_of(0));
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;

        step(0, 1, 0, 0, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 4);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        step(1, 1, 1, 1, 6);
        step(0, 1, 1, 1, 5);
        for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 0);

        // Asynchronous reset mid-count at q = 5, away from any edge.
        @(posedge clk);
        #3;
        en     = 1'b1;
        up     = 1'b1;
        reset  = 1'b0;
        model  = 0;
        #1 check("async_reset", expect_of(0));
        repeat (2) @(posedge clk);
        #1 check("reset_hold_mid", expect_of(0));
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        step(0, 0, 1, 1, 0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, M - 1));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
